// File: rtl/program_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words for instruction memory.
// Optional macro LOADER_CHECKSUM_EN adds a 4-byte trailer checking the wrapping sum of payload words.
module program_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_FLUSH,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] len_reg;
  logic [31:0] shift_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_acc;
`endif

  logic        accept;
  logic        last_byte;
  logic        last_word;
  logic        load_start;
  logic [31:0] len_next;
  logic [31:0] shifted;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
  assign accept     = rx_valid && rx_ready;
  assign last_byte  = (byte_cnt == 2'd3);
  assign len_next   = {rx_data, len_reg[31:8]};
  assign shifted    = {rx_data, shift_reg[31:8]};
  assign last_word  = (32'(word_count) + 32'd1 == len_reg);
  assign load_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LEN;
      S_LEN: begin
        if (accept && last_byte) begin
          if (len_next == 32'd0)
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
          else if (len_next > DEPTH_L) state_next = S_ERR;
          else                         state_next = S_DATA;
        end
      end
      S_DATA:  if (accept && last_byte && last_word) state_next = S_FLUSH;
`ifdef LOADER_CHECKSUM_EN
      S_FLUSH: state_next = S_CSUM;
      S_CSUM: begin
        if (accept && last_byte)
          state_next = (shifted == csum_acc) ? S_DONE : S_ERR;
      end
`else
      S_FLUSH: state_next = S_DONE;
`endif
      S_DONE:  if (start) state_next = S_LEN;
      S_ERR:   if (start) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_rst  = 1'b1;
    case (state)
      S_LEN, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_FLUSH: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // The write for a completed word is registered, so it appears the cycle after its 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      len_reg    <= 32'd0;
      shift_reg  <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_acc   <= 32'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (load_start) begin
        byte_cnt   <= 2'd0;
        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_acc   <= 32'd0;
`endif
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_LEN) len_reg   <= len_next;
        else                shift_reg <= shifted;
      end
      if (accept && state == S_DATA && last_byte) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_count[ADDR_WIDTH-1:0];
        imem_wdata <= shifted;
        word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_acc   <= csum_acc + shifted;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a model of the image format predicts writes and outcome.
module tb_program_loader;

  localparam int ADDR_WIDTH  = 8;
  localparam int DEPTH_WORDS = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   word_count;

  program_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] payload[$];
  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      writes_seen++;
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e.addr));
        check("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] payload_sum();
    logic [31:0] s = 32'd0;
    foreach (payload[i]) s += payload[i];
    return s;
  endfunction

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("byte_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_outcome(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || error) && n < 50);
  endtask

  // Reference model: image = 4-byte length, then payload words LSB first, then optional checksum trailer.
  task automatic do_load(input logic [31:0] len, input logic [31:0] trailer, input bit gaps, input bit noise);
    int  exp_wait, exp_wc, n;
    bit  exp_ok;
    exp_q.delete();
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(len[8*b +: 8], gaps);
    if (len > 32'(DEPTH_WORDS)) begin
      exp_ok = 1'b0; exp_wc = 0; exp_wait = 1;
    end else begin
      for (int i = 0; i < int'(len); i++) exp_q.push_back(wr_t'{addr: 8'(i), data: payload[i]});
      for (int i = 0; i < int'(len); i++)
        for (int b = 0; b < 4; b++) begin
          start = noise && !(i == int'(len) - 1 && b == 3);
          send_byte(payload[i][8*b +: 8], gaps);
        end
      start  = 1'b0;
      exp_wc = int'(len);
`ifdef LOADER_CHECKSUM_EN
      for (int b = 0; b < 4; b++) send_byte(trailer[8*b +: 8], gaps);
      exp_ok   = (trailer == payload_sum());
      exp_wait = 1;
`else
      exp_ok   = 1'b1;
      exp_wait = (len == 32'd0) ? 1 : 2;
`endif
    end
    rx_valid = 1'b0;
    wait_outcome(n);
    check("outcome_latency", 64'(n), 64'(exp_wait));
    check("done", 64'(done), 64'(exp_ok));
    check("error", 64'(error), 64'(!exp_ok));
    check("cpu_rst", 64'(cpu_rst), 64'(!exp_ok));
    check("rx_ready_end", 64'(rx_ready), 64'd0);
    check("busy_end", 64'(busy), 64'd0);
    check("word_count", 64'(word_count), 64'(exp_wc));
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_flags", 64'({busy, done, error, imem_we}), 64'd0);
    check("rst_regs", 64'({imem_addr, imem_wdata, word_count}), 64'd0);

    // Idle with traffic offered: nothing must be consumed or written.
    rx_valid = 1'b1; rx_data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_rx_ready", 64'(rx_ready), 64'd0);
      check("idle_cpu_rst", 64'(cpu_rst), 64'd1);
    end
    rx_valid = 1'b0;

    payload = '{32'h00500093, 32'h00A00113};
    do_load(32'd2, payload_sum(), 1'b0, 1'b0);

    payload.delete();
    do_load(32'd0, 32'd0, 1'b0, 1'b0);

    do_load(32'd257, 32'd0, 1'b0, 1'b0);
    fill_random(1);
    do_load(32'd1, payload_sum(), 1'b0, 1'b0);
    do_load(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);

    // Reset in the middle of the second payload word: only word 0 reaches memory.
    fill_random(4);
    exp_q.delete();
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(8'(32'd4 >> (8*b)), 1'b0);
    exp_q.push_back(wr_t'{addr: 8'd0, data: payload[0]});
    w0 = writes_seen;
    for (int k = 0; k < 5; k++) send_byte(payload[k/4][8*(k%4) +: 8], 1'b0);
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("midrst_rx_ready", 64'(rx_ready), 64'd0);
    check("midrst_word_count", 64'(word_count), 64'd0);
    check("midrst_writes", 64'(writes_seen - w0), 64'd1);
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    payload = '{32'h1, 32'h2};
    do_load(32'd2, 32'd3, 1'b0, 1'b0);
    do_load(32'd2, 32'd4, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      int unsigned n;
      n = $urandom_range(1, 8);
      fill_random(int'(n));
      do_load(n, ($urandom_range(0, 3) == 0) ? payload_sum() + 32'd1 : payload_sum(),
              1'b1, 1'($urandom_range(0, 1)));
    end

    fill_random(DEPTH_WORDS);
    do_load(32'(DEPTH_WORDS), payload_sum(), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time instruction loader directly upstream of the single-cycle RV32I core and its instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instruction memory write port with those words.
- Holds the core in reset until a complete, valid program image has been written.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory write port.
- DEPTH_WORDS, 256, maximum program length in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin (or restart) a load; sampled in IDLE, DONE and ERR only.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- imem_we  output  1  one-cycle instruction memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write (byte address = imem_addr*4).
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the core; active-high.
- busy  output  1  high in LEN, DATA, FLUSH (and CSUM).
- done  output  1  image loaded; core released.
- error  output  1  load aborted; core held in reset.
- word_count  output  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - cpu_rst = 1.
  - rx_ready, imem_we, busy, done, error = 0.
  - imem_addr, imem_wdata, word_count = 0.
  - Internal byte counter and length register = 0.
  - Reset mid-load aborts immediately; words already written stay in memory.
- Image format: 4-byte little-endian length L (in words), then L*4 payload bytes, little-endian per word. The first byte received is bits [7:0].
- IDLE:
  - rx_ready = 0, cpu_rst = 1.
  - start = 1 → LEN; byte counter and word_count are cleared.
- LEN:
  - rx_ready = 1; accepts 4 bytes into L.
  - On acceptance of the 4th byte:
    - L == 0 → DONE.
    - L > DEPTH_WORDS → ERR.
    - otherwise → DATA.
- DATA:
  - rx_ready = 1.
  - Bytes shift into a word assembly register; the 2-bit byte counter wraps 3→0.
  - On acceptance of the 4th byte of a word, the next cycle has:
    - imem_we = 1 for exactly one cycle;
    - imem_addr = index of that word (0, 1, …);
    - imem_wdata = the assembled word;
    - word_count incremented in the same cycle.
  - Back-to-back words at full rate are supported; no stall is ever needed.
  - When the final byte of word L-1 is accepted → FLUSH.
- FLUSH:
  - rx_ready = 0; final imem_we pulse.
  - → DONE (or → CSUM with the optional feature).
- DONE:
  - cpu_rst = 0, done = 1, rx_ready = 0.
  - cpu_rst deasserts exactly one cycle after the last imem_we.
  - start = 1 → LEN, with cpu_rst = 1 again in that same next cycle (reload).
- ERR:
  - cpu_rst = 1, error = 1, rx_ready = 0.
  - start = 1 → LEN and clears error.
- start is ignored in LEN, DATA, FLUSH and CSUM.
- rx_valid while rx_ready = 0 is ignored; no byte is consumed.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After FLUSH, state CSUM accepts 4 more bytes (little-endian) as an expected checksum.
  - The expected value is the 32-bit wrapping sum of all payload words.
  - On the 4th byte: match → DONE, mismatch → ERR.
  - L == 0 still goes LEN → CSUM, with an expected value of 0.
- Undefined:
  - No CSUM state; no trailer bytes are consumed.
  - FLUSH → DONE, and L == 0 goes LEN → DONE.

Test Plan:
- Reset then idle with rx_valid = 1 → rx_ready = 0, cpu_rst = 1, imem_we never asserted.
- start; stream L = 2, words 0x00500093, 0x00A00113 sent one byte per cycle → two imem_we pulses at addr 0 and 1 with those values; cpu_rst falls one cycle after the 2nd pulse; done = 1; word_count = 2.
- start; L = 0 → done = 1 with no imem_we pulse (checksum build: after trailer 0x00000000).
- start; L = 257 with default DEPTH_WORDS → error = 1, cpu_rst = 1, rx_ready = 0; a subsequent start plus a valid L = 1 image → done = 1, error = 0.
- rst asserted after 5 payload bytes → next cycle state IDLE, cpu_rst = 1, busy = 0; exactly 1 write occurred.
- LOADER_CHECKSUM_EN: L = 2, words 0x1, 0x2, trailer 0x3 → done; trailer 0x4 → error, cpu_rst stays 1.
